csr_access_ctrl: RTL and testbench

- Sequences every access to the CSR register bank (cycle/cycleh/instret/instreth) as a read-modify-write.
- Arbitrates the bank between two requesters: the pipeline CSR port (p_*) and a debug/host port (d_*).
- Performs the RISC-V CSRRW/CSRRS/CSRRC merge, checks legality and returns the old value.
- Sits between the execute stage / debug module and the CSR bank.

---
 rtl/csr_access_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_csr_access_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_ctrl.sv
// Read-modify-write sequencer and two-port arbiter for the cycle/instret CSR bank.
// Build option CSR_DBG_PRIO_EN: debug port has fixed priority instead of round-robin.
`timescale 1ns/1ps
module csr_access_ctrl #(
    parameter int unsigned ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 p_req_valid,
    output logic                 p_req_ready,
    input  logic [1:0]           p_req_op,
    input  logic [11:0]          p_req_addr,
    input  logic [31:0]          p_req_wdata,
    input  logic                 p_req_nowrite,
    output logic                 p_rsp_valid,
    input  logic                 p_rsp_ready,
    output logic [31:0]          p_rsp_rdata,
    output logic                 p_rsp_illegal,
    input  logic                 d_req_valid,
    output logic                 d_req_ready,
    input  logic [1:0]           d_req_op,
    input  logic [11:0]          d_req_addr,
    input  logic [31:0]          d_req_wdata,
    input  logic                 d_req_nowrite,
    output logic                 d_rsp_valid,
    input  logic                 d_rsp_ready,
    output logic [31:0]          d_rsp_rdata,
    output logic                 d_rsp_illegal,
    output logic [11:0]          csr_raddr,
    input  logic [31:0]          csr_rdata,
    output logic                 csr_wen,
    output logic [11:0]          csr_waddr,
    output logic [31:0]          csr_wdata,
    output logic                 busy,
    output logic [ILL_CNT_W-1:0] ill_cnt
);
    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;
    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_RESP} state_t;

    state_t                r_state;
    logic [1:0]            r_op;
    logic [AW-1:0]         r_addr;
    logic [DW-1:0]         r_wdata;
    logic                  r_nowrite;
    logic                  r_src_dbg;
    logic [DW-1:0]         r_old;
    logic [DW-1:0]         r_new;
    logic                  r_illegal;
    logic                  r_wen;
    logic                  r_p_rsp_valid;
    logic                  r_d_rsp_valid;
    logic [ILL_CNT_W-1:0]  r_ill_cnt;
`ifndef CSR_DBG_PRIO_EN
    logic                  r_last_dbg;
`endif

    logic                  w_accept;
    logic                  w_grant_dbg;
    logic                  w_addr_ok;
    logic                  w_wr_intent;
    logic                  w_illegal;
    logic                  w_rd_only;
    logic                  w_rsp_taken;
    logic [DW-1:0]         w_new;

`ifdef CSR_DBG_PRIO_EN
    assign w_grant_dbg = d_req_valid;
`else
    // On a tie, the requester that was not granted last time wins.
    assign w_grant_dbg = d_req_valid & (~p_req_valid | ~r_last_dbg);
`endif

    // A grant in a reset cycle would be lost, so readies are held low then.
    assign w_accept    = nrst & (r_state == ST_IDLE) & (p_req_valid | d_req_valid);
    assign p_req_ready = w_accept & ~w_grant_dbg;
    assign d_req_ready = w_accept & w_grant_dbg;

    assign w_addr_ok   = (r_addr == 12'hC00) | (r_addr == 12'hC80) |
                         (r_addr == 12'hC02) | (r_addr == 12'hC82);
    assign w_wr_intent = (r_op == OP_RW) | (((r_op == OP_RS) | (r_op == OP_RC)) & ~r_nowrite);
    assign w_illegal   = ~w_addr_ok | (r_op == 2'b00) |
                         (~r_src_dbg & w_wr_intent & (r_addr[11:10] == 2'b11));
    assign w_rd_only   = ((r_op == OP_RS) | (r_op == OP_RC)) & r_nowrite;
    assign w_rsp_taken = r_src_dbg ? d_rsp_ready : p_rsp_ready;

    always_comb begin
        w_new = csr_rdata;
        case (r_op)
            OP_RW:   w_new = r_wdata;
            OP_RS:   w_new = csr_rdata | r_wdata;
            OP_RC:   w_new = csr_rdata & ~r_wdata;
            default: w_new = csr_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state       <= ST_IDLE;
            r_op          <= 2'b00;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_nowrite     <= 1'b0;
            r_src_dbg     <= 1'b0;
            r_old         <= '0;
            r_new         <= '0;
            r_illegal     <= 1'b0;
            r_wen         <= 1'b0;
            r_p_rsp_valid <= 1'b0;
            r_d_rsp_valid <= 1'b0;
            r_ill_cnt     <= '0;
`ifndef CSR_DBG_PRIO_EN
            r_last_dbg    <= 1'b1;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op      <= w_grant_dbg ? d_req_op      : p_req_op;
                        r_addr    <= w_grant_dbg ? d_req_addr    : p_req_addr;
                        r_wdata   <= w_grant_dbg ? d_req_wdata   : p_req_wdata;
                        r_nowrite <= w_grant_dbg ? d_req_nowrite : p_req_nowrite;
                        r_src_dbg <= w_grant_dbg;
`ifndef CSR_DBG_PRIO_EN
                        r_last_dbg <= w_grant_dbg;
`endif
                        r_state   <= ST_READ;
                    end
                end
                ST_READ: begin
                    r_old     <= w_illegal ? '0 : csr_rdata;
                    r_new     <= w_new;
                    r_illegal <= w_illegal;
                    if (w_illegal | w_rd_only) begin
                        r_state       <= ST_RESP;
                        r_p_rsp_valid <= ~r_src_dbg;
                        r_d_rsp_valid <= r_src_dbg;
                        if (w_illegal && (r_ill_cnt != {ILL_CNT_W{1'b1}})) begin
                            r_ill_cnt <= r_ill_cnt + ILL_CNT_W'(1);
                        end
                    end else begin
                        r_state <= ST_WRITE;
                        r_wen   <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    r_wen         <= 1'b0;
                    r_state       <= ST_RESP;
                    r_p_rsp_valid <= ~r_src_dbg;
                    r_d_rsp_valid <= r_src_dbg;
                end
                ST_RESP: begin
                    if (w_rsp_taken) begin
                        r_state       <= ST_IDLE;
                        r_p_rsp_valid <= 1'b0;
                        r_d_rsp_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign csr_raddr     = r_addr;
    assign csr_waddr     = r_addr;
    assign csr_wdata     = r_new;
    assign csr_wen       = r_wen & nrst;
    assign busy          = (r_state != ST_IDLE);
    assign ill_cnt       = r_ill_cnt;
    assign p_rsp_valid   = r_p_rsp_valid;
    assign d_rsp_valid   = r_d_rsp_valid;
    assign p_rsp_rdata   = r_old;
    assign d_rsp_rdata   = r_old;
    assign p_rsp_illegal = r_illegal;
    assign d_rsp_illegal = r_illegal;
endmodule

// File: tb/tb_csr_access_ctrl.sv
// Scoreboard bench for csr_access_ctrl with a behavioural counter bank and request model.
`timescale 1ns/1ps
module tb_csr_access_ctrl;
    localparam int unsigned ILL_CNT_W = 8;
    localparam int ILL_MAX = (1 << ILL_CNT_W) - 1;
`ifdef CSR_DBG_PRIO_EN
    localparam bit DBG_PRIO = 1'b1;
`else
    localparam bit DBG_PRIO = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        nowrite;
    } req_t;
    typedef struct { logic [31:0] rdata; logic ill; int first; } exp_t;
    typedef struct { logic [11:0] addr; logic [31:0] data; int cyc; } wexp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nrst;
    logic        p_req_valid, p_req_ready, p_req_nowrite, p_rsp_valid, p_rsp_ready, p_rsp_illegal;
    logic        d_req_valid, d_req_ready, d_req_nowrite, d_rsp_valid, d_rsp_ready, d_rsp_illegal;
    logic [1:0]  p_req_op, d_req_op;
    logic [11:0] p_req_addr, d_req_addr, csr_raddr, csr_waddr;
    logic [31:0] p_req_wdata, d_req_wdata, p_rsp_rdata, d_rsp_rdata, csr_rdata, csr_wdata;
    logic        csr_wen, busy;
    logic [ILL_CNT_W-1:0] ill_cnt;

    csr_access_ctrl #(.ILL_CNT_W(ILL_CNT_W)) dut (
        .clk(clk), .nrst(nrst),
        .p_req_valid(p_req_valid), .p_req_ready(p_req_ready), .p_req_op(p_req_op),
        .p_req_addr(p_req_addr), .p_req_wdata(p_req_wdata), .p_req_nowrite(p_req_nowrite),
        .p_rsp_valid(p_rsp_valid), .p_rsp_ready(p_rsp_ready), .p_rsp_rdata(p_rsp_rdata),
        .p_rsp_illegal(p_rsp_illegal),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_op(d_req_op),
        .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_nowrite(d_req_nowrite),
        .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_rdata(d_rsp_rdata),
        .d_rsp_illegal(d_rsp_illegal),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_wen(csr_wen),
        .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .busy(busy), .ill_cnt(ill_cnt)
    );

    // Counter bank: both 64-bit counters advance every cycle unless a write is in progress.
    logic [63:0] bank_cyc = 64'h0000_0003_FFFF_FFF0;
    logic [63:0] bank_ins = 64'h0000_0012_0000_0100;
    always @(posedge clk) begin
        if (csr_wen) begin
            case (csr_waddr)
                12'hC00: bank_cyc[31:0]  <= csr_wdata;
                12'hC80: bank_cyc[63:32] <= csr_wdata;
                12'hC02: bank_ins[31:0]  <= csr_wdata;
                12'hC82: bank_ins[63:32] <= csr_wdata;
                default: ;
            endcase
        end else begin
            bank_cyc <= bank_cyc + 64'd1;
            bank_ins <= bank_ins + 64'd1;
        end
    end

    function automatic logic [31:0] bank_word(input logic [11:0] a, input logic [63:0] c,
                                              input logic [63:0] i);
        case (a)
            12'hC00: return c[31:0];
            12'hC80: return c[63:32];
            12'hC02: return i[31:0];
            12'hC82: return i[63:32];
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb csr_rdata = bank_word(csr_raddr, bank_cyc, bank_ins);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;
    req_t pq[$], dq[$];
    exp_t pexp[$], dexp[$];
    wexp_t wq[$];
    bit p_force = 1'b0;
    bit model_busy = 1'b0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, expv);
        end
    endfunction

    // Reference model: response and write derived from the access rules at accept time.
    function automatic void predict(input bit dbg, input req_t r);
        exp_t e;
        wexp_t w;
        logic legal, wr_int, ill, ro;
        logic [31:0] old, nv;
        legal  = r.addr inside {12'hC00, 12'hC80, 12'hC02, 12'hC82};
        wr_int = (r.op == 2'b01) || ((r.op == 2'b10 || r.op == 2'b11) && !r.nowrite);
        ill    = !legal || (r.op == 2'b00) || (!dbg && wr_int && r.addr[11:10] == 2'b11);
        ro     = (r.op == 2'b10 || r.op == 2'b11) && r.nowrite;
        old    = bank_word(r.addr, bank_cyc + 64'd1, bank_ins + 64'd1);
        case (r.op)
            2'b01:   nv = r.wdata;
            2'b10:   nv = old | r.wdata;
            2'b11:   nv = old & ~r.wdata;
            default: nv = 32'h0;
        endcase
        e.rdata = ill ? 32'h0 : old;
        e.ill   = ill;
        e.first = cyc + ((ill || ro) ? 2 : 3);
        if (dbg) dexp.push_back(e); else pexp.push_back(e);
        if (!ill && !ro) begin
            w.addr = r.addr; w.data = nv; w.cyc = cyc + 2;
            wq.push_back(w);
        end
    endfunction

    // Request driver: changes inputs just after the rising edge, detects accept at the falling edge.
    initial begin
        req_t cur_p, cur_d;
        bit acc_p, acc_d;
        acc_p = 1'b0; acc_d = 1'b0; cur_p = '0; cur_d = '0;
        p_req_valid = 1'b0; d_req_valid = 1'b0;
        {p_req_op, p_req_addr, p_req_wdata, p_req_nowrite} = '0;
        {d_req_op, d_req_addr, d_req_wdata, d_req_nowrite} = '0;
        forever begin
            @(posedge clk); #1;
            if (acc_p) begin p_req_valid = 1'b0; acc_p = 1'b0; end
            if (acc_d) begin d_req_valid = 1'b0; acc_d = 1'b0; end
            if (!p_req_valid && pq.size() > 0) begin
                cur_p = pq.pop_front();
                {p_req_op, p_req_addr, p_req_wdata, p_req_nowrite} = cur_p;
                p_req_valid = 1'b1;
            end
            if (!d_req_valid && dq.size() > 0) begin
                cur_d = dq.pop_front();
                {d_req_op, d_req_addr, d_req_wdata, d_req_nowrite} = cur_d;
                d_req_valid = 1'b1;
            end
            @(negedge clk);
            if (p_req_valid && p_req_ready) begin predict(1'b0, cur_p); acc_p = 1'b1; end
            if (d_req_valid && d_req_ready) begin predict(1'b1, cur_d); acc_d = 1'b1; end
        end
    end

    initial begin
        p_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            p_rsp_ready = p_force ? 1'b0 : ($urandom_range(0, 3) != 0);
            d_rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: arbitration, bank writes and responses against the model's expectations.
    initial begin
        bit prev_rst, last_d, exp_d, anyv;
        bit inprog [2];
        logic [31:0] hold_r [2];
        logic hold_i [2];
        logic mv, mi, rr;
        logic [31:0] mr;
        int ill_model;
        exp_t e;
        prev_rst = 1'b0; last_d = 1'b1; ill_model = 0;
        inprog = '{1'b0, 1'b0};
        hold_r = '{32'h0, 32'h0};
        hold_i = '{1'b0, 1'b0};
        forever begin
            @(negedge clk);
            if (!nrst) begin
                chk("rst_csr_wen", 32'(csr_wen), 32'h0);
                chk("rst_p_req_ready", 32'(p_req_ready), 32'h0);
                chk("rst_d_req_ready", 32'(d_req_ready), 32'h0);
                if (prev_rst) begin
                    chk("rst_busy", 32'(busy), 32'h0);
                    chk("rst_ill_cnt", 32'(ill_cnt), 32'h0);
                    chk("rst_p_rsp_valid", 32'(p_rsp_valid), 32'h0);
                    chk("rst_d_rsp_valid", 32'(d_rsp_valid), 32'h0);
                    chk("rst_rdata", p_rsp_rdata, 32'h0);
                    chk("rst_csr_wdata", csr_wdata, 32'h0);
                    chk("rst_csr_addr", 32'({csr_raddr, csr_waddr}), 32'h0);
                end
                pexp.delete(); dexp.delete(); wq.delete();
                inprog = '{1'b0, 1'b0};
                model_busy = 1'b0; last_d = 1'b1; ill_model = 0;
                prev_rst = 1'b1;
            end else begin
                prev_rst = 1'b0;
                chk("busy", 32'(busy), 32'(model_busy));
                if (!model_busy) begin
                    anyv  = p_req_valid || d_req_valid;
                    exp_d = DBG_PRIO ? d_req_valid : (d_req_valid && (!p_req_valid || !last_d));
                    chk("p_req_ready", 32'(p_req_ready), 32'(anyv && !exp_d));
                    chk("d_req_ready", 32'(d_req_ready), 32'(anyv && exp_d));
                    if (anyv) begin model_busy = 1'b1; last_d = exp_d; end
                end else begin
                    chk("p_req_ready_busy", 32'(p_req_ready), 32'h0);
                    chk("d_req_ready_busy", 32'(d_req_ready), 32'h0);
                end
                if (csr_wen) begin
                    if (wq.size() == 0 || wq[0].cyc != cyc) begin
                        chk("unexpected_csr_wen", 32'(csr_wen), 32'h0);
                    end else begin
                        chk("csr_waddr", 32'(csr_waddr), 32'(wq[0].addr));
                        chk("csr_wdata", csr_wdata, wq[0].data);
                        void'(wq.pop_front());
                    end
                end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
                    chk("missing_csr_wen", 32'(csr_wen), 32'h1);
                    void'(wq.pop_front());
                end
                for (int k = 0; k < 2; k++) begin
                    mv = (k == 0) ? p_rsp_valid : d_rsp_valid;
                    mr = (k == 0) ? p_rsp_rdata : d_rsp_rdata;
                    mi = (k == 0) ? p_rsp_illegal : d_rsp_illegal;
                    rr = (k == 0) ? p_rsp_ready : d_rsp_ready;
                    if (mv) begin
                        if (!inprog[k]) begin
                            if ((k == 0 && pexp.size() == 0) || (k == 1 && dexp.size() == 0)) begin
                                chk($sformatf("unexpected_rsp_port%0d", k), 32'(mv), 32'h0);
                            end else begin
                                e = (k == 0) ? pexp.pop_front() : dexp.pop_front();
                                chk($sformatf("rsp_latency_port%0d", k), 32'(cyc), 32'(e.first));
                                chk($sformatf("rsp_rdata_port%0d", k), mr, e.rdata);
                                chk($sformatf("rsp_illegal_port%0d", k), 32'(mi), 32'(e.ill));
                                if (e.ill && ill_model < ILL_MAX) ill_model++;
                                chk("ill_cnt", 32'(ill_cnt), 32'(ill_model));
                            end
                            inprog[k] = 1'b1; hold_r[k] = mr; hold_i[k] = mi;
                        end else begin
                            chk($sformatf("rsp_hold_rdata_port%0d", k), mr, hold_r[k]);
                            chk($sformatf("rsp_hold_illegal_port%0d", k), 32'(mi), 32'(hold_i[k]));
                        end
                        if (rr) begin inprog[k] = 1'b0; model_busy = 1'b0; end
                    end else if (inprog[k]) begin
                        chk($sformatf("rsp_valid_dropped_port%0d", k), 32'(mv), 32'h1);
                        inprog[k] = 1'b0; model_busy = 1'b0;
                    end else if ((k == 0 && pexp.size() > 0 && pexp[0].first <= cyc) ||
                                 (k == 1 && dexp.size() > 0 && dexp[0].first <= cyc)) begin
                        chk($sformatf("missing_rsp_port%0d", k), 32'(mv), 32'h1);
                        if (k == 0) void'(pexp.pop_front()); else void'(dexp.pop_front());
                        model_busy = 1'b0;
                    end
                end
            end
        end
    end

    task automatic quiet(input int budget);
        int n = 0;
        while ((pq.size() > 0 || dq.size() > 0 || p_req_valid || d_req_valid || pexp.size() > 0 ||
                dexp.size() > 0 || wq.size() > 0 || model_busy || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            vectors++; miscompares++;
            $display("FAIL quiet_timeout at cycle %0d: still busy after %0d cycles", cyc, budget);
        end
        repeat (2) @(negedge clk);
    endtask

    function automatic req_t rand_req();
        logic [11:0] legal_a [4];
        req_t r;
        legal_a = '{12'hC00, 12'hC80, 12'hC02, 12'hC82};
        r.op      = 2'($urandom_range(0, 3));
        r.addr    = ($urandom_range(0, 9) < 8) ? legal_a[$urandom_range(0, 3)]
                                               : 12'($urandom_range(0, 4095));
        r.wdata   = $urandom;
        r.nowrite = 1'($urandom_range(0, 1));
        return r;
    endfunction

    function automatic req_t ill_req(input bit pipe);
        logic [11:0] legal_a [4];
        req_t r;
        int sel;
        legal_a   = '{12'hC00, 12'hC80, 12'hC02, 12'hC82};
        sel       = $urandom_range(0, pipe ? 2 : 1);
        r.wdata   = $urandom;
        r.nowrite = 1'($urandom_range(0, 1));
        r.addr    = legal_a[$urandom_range(0, 3)];
        r.op      = 2'b00;
        if (sel == 0) begin
            r.addr = 12'($urandom_range(0, 12'h7FF));
            r.op   = 2'($urandom_range(1, 3));
        end else if (sel == 2) begin
            r.op = 2'b01;
        end
        return r;
    endfunction

    initial begin
        int n;
        nrst = 1'b0;
        repeat (3) @(posedge clk);
        #1 nrst = 1'b1;

        pq.push_back('{op: 2'b10, addr: 12'hC00, wdata: 32'h0000_0001, nowrite: 1'b1});
        dq.push_back('{op: 2'b01, addr: 12'hC82, wdata: 32'h0000_00A5, nowrite: 1'b0});
        dq.push_back('{op: 2'b01, addr: 12'hC00, wdata: 32'h0000_00F0, nowrite: 1'b0});
        dq.push_back('{op: 2'b11, addr: 12'hC00, wdata: 32'h0000_0030, nowrite: 1'b0});
        pq.push_back('{op: 2'b01, addr: 12'hC02, wdata: 32'h1234_0000, nowrite: 1'b0});
        pq.push_back('{op: 2'b10, addr: 12'h300, wdata: 32'h0000_0000, nowrite: 1'b1});
        quiet(500);

        for (int i = 0; i < 6; i++) begin
            pq.push_back('{op: 2'b10, addr: 12'hC02, wdata: 32'h0, nowrite: 1'b1});
            dq.push_back('{op: 2'b11, addr: 12'hC80, wdata: 32'h0, nowrite: 1'b1});
        end
        quiet(500);

        p_force = 1'b1;
        pq.push_back('{op: 2'b10, addr: 12'hC80, wdata: 32'h0, nowrite: 1'b1});
        dq.push_back('{op: 2'b10, addr: 12'hC02, wdata: 32'h0, nowrite: 1'b1});
        repeat (8) @(posedge clk);
        p_force = 1'b0;
        quiet(500);

        dq.push_back('{op: 2'b01, addr: 12'hC80, wdata: 32'h1234_5678, nowrite: 1'b0});
        n = 0;
        do begin @(negedge clk); n++; end while (!d_req_ready && n < 50);
        pq.push_back('{op: 2'b10, addr: 12'hC82, wdata: 32'h0, nowrite: 1'b1});
        @(posedge clk); @(posedge clk);
        #1 nrst = 1'b0;
        @(posedge clk);
        #1 nrst = 1'b1;
        quiet(500);

        for (int i = 0; i < 150; i++) begin
            pq.push_back(ill_req(1'b1));
            dq.push_back(ill_req(1'b0));
        end
        quiet(8000);
        chk("ill_cnt_saturated", 32'(ill_cnt), 32'(ILL_MAX));

        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 1) == 1) pq.push_back(rand_req());
            if ($urandom_range(0, 1) == 1) dq.push_back(rand_req());
            repeat ($urandom_range(0, 6)) @(posedge clk);
        end
        quiet(8000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
        $fatal(1, "watchdog expired");
    end
endmodule
